// File: rtl/rv_mem_pkg.sv
// ============================================================================
// Module  : rv_mem_pkg
// Purpose : funct3 codes, FSM encoding and lane-mask helpers for the LSU.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package rv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_SECOND = 1'b1
    } mau_state_t;

    // Unaligned lane pattern; the size lives in funct3[1:0] for both signed and unsigned forms.
    function automatic logic [3:0] smask_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   smask_of = 4'b0001;
            2'b01:   smask_of = 4'b0011;
            2'b10:   smask_of = 4'b1111;
            default: smask_of = 4'b0000;
        endcase
    endfunction

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we)
            f3_legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        else
            f3_legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                       (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_unit_if.sv
// ============================================================================
// Module  : mem_access_unit_if
// Purpose : Pipeline request/response and DMEM signals of the load/store unit.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface mem_access_unit_if;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        stall;
    logic        resp_valid;
    logic [31:0] load_data;
    logic        illegal;
    logic        dmem_we;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_A;
    logic [31:0] dmem_wd;
    logic [31:0] dmem_rd;

    modport master (
        output req_valid, req_we, funct3, addr, store_data,
        input  stall, resp_valid, load_data, illegal
    );

    modport slave (
        input  req_valid, req_we, funct3, addr, store_data, dmem_rd,
        output stall, resp_valid, load_data, illegal,
               dmem_we, dmem_wmask, dmem_A, dmem_wd
    );

    modport mem (
        input  dmem_we, dmem_wmask, dmem_A, dmem_wd,
        output dmem_rd
    );
endinterface

`default_nettype wire

// File: rtl/mem_access_unit_load_extend.sv
// ============================================================================
// Module  : load_extend
// Purpose : Sign/zero extension of an LSB-justified load value by funct3.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module load_extend
    import rv_mem_pkg::*;
(
    input  wire logic [2:0]  i_funct3,
    input  wire logic [31:0] i_value,
    output logic      [31:0] o_ext
);

    always_comb begin
        o_ext = i_value;
        case (i_funct3)
            F3_B:    o_ext = {{24{i_value[7]}}, i_value[7:0]};
            F3_H:    o_ext = {{16{i_value[15]}}, i_value[15:0]};
            F3_BU:   o_ext = {24'd0, i_value[7:0]};
            F3_HU:   o_ext = {16'd0, i_value[15:0]};
            default: o_ext = i_value;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module  : mem_access_unit
// Purpose : Byte-addressed load/store to word DMEM, splitting unaligned accesses.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_access_unit
    import rv_mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  wire logic         clk,
    input  wire logic         rst,
    mem_access_unit_if.slave  bus
);

    localparam logic [31:0] c_addr_mask = (32'd1 << DEPTH_LOG2) - 32'd1;

    mau_state_t  r_state, w_state_nxt;

    logic [29:0] r_word;
    logic [1:0]  r_off;
    logic [2:0]  r_funct3;
    logic        r_we;
    logic [31:0] r_store_data;
    logic [31:0] r_lo;
    logic        r_resp_valid;
    logic        r_illegal;
    logic [31:0] r_load_data;

    logic        w_second;
    logic [1:0]  w_off;
    logic [2:0]  w_f3;
    logic        w_we;
    logic        w_legal;
    logic        w_split;
    logic [3:0]  w_smask;
    logic [7:0]  w_mask8;
    logic [63:0] w_data64;
    logic [29:0] w_word;
    logic [31:0] w_a32;
    logic [5:0]  w_hi_sh;
    logic [31:0] w_rd_shift;
    logic [31:0] w_ext_in;
    logic [31:0] w_ext;
    logic        w_first_beat;
    logic        w_complete;
    logic        w_illegal;

    load_extend u_load_extend (
        .i_funct3 (w_f3),
        .i_value  (w_ext_in),
        .o_ext    (w_ext)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_second       = (r_state == ST_SECOND);
        w_off          = w_second ? r_off    : bus.addr[1:0];
        w_f3           = w_second ? r_funct3 : bus.funct3;
        w_we           = w_second ? r_we     : bus.req_we;
        w_legal        = f3_legal(bus.req_we, bus.funct3);
        w_split        = w_legal && (((bus.funct3[1:0] == 2'b01) && (bus.addr[1:0] == 2'b11)) ||
                                     ((bus.funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00)));
        w_smask        = smask_of(w_f3);
        // The 8-lane / 64-bit views hold both beats: low half is beat 1, high half is beat 2.
        w_mask8        = {4'b0000, w_smask} << w_off;
        w_data64       = {32'd0, (w_second ? r_store_data : bus.store_data)} << {w_off, 3'b000};
        w_word         = w_second ? (r_word + 30'd1) : bus.addr[31:2];
        w_a32          = {2'b00, w_word} & c_addr_mask;
        w_hi_sh        = 6'd32 - {1'b0, w_off, 3'b000};
        w_rd_shift     = bus.dmem_rd >> {w_off, 3'b000};
        w_ext_in       = w_second ? ((bus.dmem_rd << w_hi_sh) | r_lo) : w_rd_shift;

        w_first_beat   = 1'b0;
        w_complete     = 1'b0;
        w_illegal      = 1'b0;
        bus.stall      = 1'b0;
        bus.dmem_we    = 1'b0;
        bus.dmem_wmask = 4'b0000;
        bus.dmem_A     = 32'd0;
        bus.dmem_wd    = 32'd0;

        if (!rst) begin
            bus.dmem_A     = w_a32;
            bus.dmem_wmask = w_second ? w_mask8[7:4]   : w_mask8[3:0];
            bus.dmem_wd    = w_second ? w_data64[63:32] : w_data64[31:0];
            if (w_second) begin
                bus.dmem_we = r_we;
                w_complete  = 1'b1;
                w_state_nxt = ST_IDLE;
            end else if (bus.req_valid) begin
                if (!w_legal) begin
                    w_illegal = 1'b1;
                end else begin
                    bus.dmem_we = bus.req_we;
                    if (w_split) begin
                        w_first_beat = 1'b1;
                        bus.stall    = 1'b1;
                        w_state_nxt  = ST_SECOND;
                    end else begin
                        w_complete   = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp_valid <= 1'b0;
            r_illegal    <= 1'b0;
            r_load_data  <= 32'd0;
            r_lo         <= 32'd0;
            r_word       <= 30'd0;
            r_off        <= 2'd0;
            r_funct3     <= 3'd0;
            r_we         <= 1'b0;
            r_store_data <= 32'd0;
        end else begin
            r_resp_valid <= w_complete;
            r_illegal    <= w_illegal;
            if (w_complete && !w_we)
                r_load_data <= w_ext;
            if (w_first_beat) begin
                r_word       <= bus.addr[31:2];
                r_off        <= bus.addr[1:0];
                r_funct3     <= bus.funct3;
                r_we         <= bus.req_we;
                r_store_data <= bus.store_data;
                r_lo         <= w_rd_shift;
            end
        end
    end

    assign bus.resp_valid = r_resp_valid;
    assign bus.illegal    = r_illegal;
    assign bus.load_data  = r_load_data;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module  : tb_mem_access_unit
// Purpose : Directed self-checking bench for mem_access_unit with a DMEM model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_access_unit;
    import rv_mem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [31:0] mem [0:1023] = '{default: 32'd0};

    mem_access_unit_if bus ();

    mem_access_unit #(.DEPTH_LOG2(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.dmem_rd = mem[bus.dmem_A[9:0]];

    always @(posedge clk) begin
        if (bus.dmem_we) begin
            for (int i = 0; i < 4; i++)
                if (bus.dmem_wmask[i])
                    mem[bus.dmem_A[9:0]][8*i +: 8] <= bus.dmem_wd[8*i +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd);
        bus.req_valid  = v;
        bus.req_we     = we;
        bus.funct3     = f3;
        bus.addr       = a;
        bus.store_data = sd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b1, 1'b1, F3_W, 32'h41, 32'h12345678);
        @(negedge clk);
        chk("rst_we", {31'd0, bus.dmem_we}, 32'd0);
        chk("rst_stall", {31'd0, bus.stall}, 32'd0);
        chk("rst_A", bus.dmem_A, 32'd0);
        step();
        step();
        rst = 1'b0;
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        chk("rst_resp", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst_illegal", {31'd0, bus.illegal}, 32'd0);
        chk("rst_ld", bus.load_data, 32'd0);
        chk("rst_nowrite", mem[16], 32'd0);

        // SW then LW back to back
        drive(1'b1, 1'b1, F3_W, 32'h40, 32'hDEADBEEF);
        @(negedge clk);
        chk("sw_A", bus.dmem_A, 32'h10);
        chk("sw_mask", {28'd0, bus.dmem_wmask}, 32'hF);
        chk("sw_wd", bus.dmem_wd, 32'hDEADBEEF);
        chk("sw_we", {31'd0, bus.dmem_we}, 32'd1);
        chk("sw_stall", {31'd0, bus.stall}, 32'd0);
        step();
        drive(1'b1, 1'b0, F3_W, 32'h40, 32'h0);
        chk("sw_resp", {31'd0, bus.resp_valid}, 32'd1);
        chk("sw_ld_kept", bus.load_data, 32'd0);
        @(negedge clk);
        chk("lw_stall", {31'd0, bus.stall}, 32'd0);
        chk("lw_we", {31'd0, bus.dmem_we}, 32'd0);
        step();
        chk("lw_resp", {31'd0, bus.resp_valid}, 32'd1);
        chk("lw_data", bus.load_data, 32'hDEADBEEF);

        // Byte/half offsets against word 0x10 = 0x80FF7F01
        drive(1'b1, 1'b1, F3_W, 32'h40, 32'h80FF7F01);
        step();
        drive(1'b1, 1'b0, F3_B, 32'h43, 32'h0);
        step();
        chk("lb43", bus.load_data, 32'hFFFFFF80);
        drive(1'b1, 1'b0, F3_BU, 32'h43, 32'h0);
        step();
        chk("lbu43", bus.load_data, 32'h00000080);
        drive(1'b1, 1'b0, F3_H, 32'h42, 32'h0);
        step();
        chk("lh42", bus.load_data, 32'hFFFF80FF);
        drive(1'b1, 1'b0, F3_HU, 32'h42, 32'h0);
        step();
        chk("lhu42", bus.load_data, 32'h000080FF);
        drive(1'b1, 1'b0, F3_H, 32'h40, 32'h0);
        step();
        chk("lh40", bus.load_data, 32'h00007F01);
        drive(1'b1, 1'b1, F3_B, 32'h45, 32'h000000AB);
        @(negedge clk);
        chk("sb45_mask", {28'd0, bus.dmem_wmask}, 32'h2);
        chk("sb45_wd", bus.dmem_wd, 32'h0000AB00);
        step();

        // Split word store at 0x41
        drive(1'b1, 1'b1, F3_W, 32'h41, 32'h11223344);
        @(negedge clk);
        chk("ssw1_stall", {31'd0, bus.stall}, 32'd1);
        chk("ssw1_A", bus.dmem_A, 32'h10);
        chk("ssw1_mask", {28'd0, bus.dmem_wmask}, 32'hE);
        chk("ssw1_wd", bus.dmem_wd, 32'h22334400);
        step();
        @(negedge clk);
        chk("ssw2_stall", {31'd0, bus.stall}, 32'd0);
        chk("ssw2_A", bus.dmem_A, 32'h11);
        chk("ssw2_mask", {28'd0, bus.dmem_wmask}, 32'h1);
        chk("ssw2_wd", bus.dmem_wd, 32'h00000011);
        chk("ssw2_we", {31'd0, bus.dmem_we}, 32'd1);
        step();
        chk("ssw_resp", {31'd0, bus.resp_valid}, 32'd1);
        chk("ssw_mem10", mem[16], 32'h22334401);
        chk("ssw_mem11", mem[17], 32'h0000AB11);

        // Split word load at 0x41
        drive(1'b1, 1'b0, F3_W, 32'h41, 32'h0);
        @(negedge clk);
        chk("slw_stall_n", {31'd0, bus.stall}, 32'd1);
        step();
        chk("slw_resp_n1", {31'd0, bus.resp_valid}, 32'd0);
        @(negedge clk);
        chk("slw_stall_n1", {31'd0, bus.stall}, 32'd0);
        step();
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        chk("slw_resp", {31'd0, bus.resp_valid}, 32'd1);
        chk("slw_data", bus.load_data, 32'h11223344);

        // Split LH at 0x47
        drive(1'b1, 1'b1, F3_W, 32'h44, 32'h44332211);
        step();
        drive(1'b1, 1'b1, F3_B, 32'h48, 32'h00000088);
        step();
        drive(1'b1, 1'b0, F3_H, 32'h47, 32'h0);
        @(negedge clk);
        chk("slh_stall", {31'd0, bus.stall}, 32'd1);
        step();
        step();
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        chk("slh_data", bus.load_data, 32'hFFFF8844);

        // Word-index wrap
        drive(1'b1, 1'b1, F3_W, 32'hFFFFFFFE, 32'hA1B2C3D4);
        @(negedge clk);
        chk("wrap1_A", bus.dmem_A, 32'h3FF);
        chk("wrap1_mask", {28'd0, bus.dmem_wmask}, 32'hC);
        chk("wrap1_wd", bus.dmem_wd, 32'hC3D40000);
        step();
        @(negedge clk);
        chk("wrap2_A", bus.dmem_A, 32'h0);
        chk("wrap2_mask", {28'd0, bus.dmem_wmask}, 32'h3);
        chk("wrap2_wd", bus.dmem_wd, 32'h0000A1B2);
        step();
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);

        // Reset during the second beat of a split store
        drive(1'b1, 1'b1, F3_W, 32'h81, 32'hCAFEF00D);
        @(negedge clk);
        chk("rsec_stall", {31'd0, bus.stall}, 32'd1);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("rsec_we", {31'd0, bus.dmem_we}, 32'd0);
        step();
        rst = 1'b0;
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        chk("rsec_resp0", {31'd0, bus.resp_valid}, 32'd0);
        step();
        chk("rsec_resp1", {31'd0, bus.resp_valid}, 32'd0);
        chk("rsec_mem20", mem[32], 32'hFEF00D00);
        chk("rsec_mem21", mem[33], 32'h0);
        drive(1'b1, 1'b0, F3_W, 32'h80, 32'h0);
        @(negedge clk);
        chk("rsec_idle_stall", {31'd0, bus.stall}, 32'd0);
        chk("rsec_idle_A", bus.dmem_A, 32'h20);
        step();
        chk("rsec_lw", bus.load_data, 32'hFEF00D00);

        // Illegal funct3
        drive(1'b1, 1'b0, 3'b011, 32'h40, 32'h0);
        @(negedge clk);
        chk("ill_ld_we", {31'd0, bus.dmem_we}, 32'd0);
        chk("ill_ld_stall", {31'd0, bus.stall}, 32'd0);
        step();
        drive(1'b1, 1'b1, F3_BU, 32'h40, 32'h55555555);
        chk("ill_ld_pulse", {31'd0, bus.illegal}, 32'd1);
        chk("ill_ld_resp", {31'd0, bus.resp_valid}, 32'd0);
        chk("ill_ld_keep", bus.load_data, 32'hFEF00D00);
        @(negedge clk);
        chk("ill_st_we", {31'd0, bus.dmem_we}, 32'd0);
        step();
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        chk("ill_st_pulse", {31'd0, bus.illegal}, 32'd1);
        chk("ill_st_mem", mem[16], 32'h22334401);
        step();
        chk("ill_clear", {31'd0, bus.illegal}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
